// File: rtl/nrs_re_demapper.sv
// rtl/nrs_re_demapper.sv - NB-IoT subframe RE buffer and NRS demapper feeding the channel estimator
// NRS_DEMAP_PINGPONG_EN selects two banks so the FFT can fill one while the estimator reads the other.
module nrs_re_demapper #(
  parameter int WIDTH_RX = 16,
  parameter int N_SC     = 12,
  parameter int N_SYM    = 14
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fft_valid,
  input  logic signed [WIDTH_RX-1:0] fft_r,
  input  logic signed [WIDTH_RX-1:0] fft_i,
  output logic                       fft_ready,
  input  logic [2:0]                 v_shift,
  input  logic [3:0]                 col_demap,
  input  logic                       demap_read,
  input  logic                       est_ack_demap,
  output logic                       demap_ready,
  output logic signed [WIDTH_RX-1:0] rx_r,
  output logic signed [WIDTH_RX-1:0] rx_i,
  output logic                       col_err
);

`ifdef NRS_DEMAP_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif
  localparam int DEPTH = N_SC * N_SYM;
  localparam int AW    = $clog2(NB * DEPTH);

  typedef enum logic [1:0] {EMPTY, FILL, FULL} bank_state_t;

  bank_state_t           state   [2];
  logic [2:0]            vs_bank [2];
  logic [2*WIDTH_RX-1:0] mem     [NB*DEPTH];

  logic [3:0]    sc, sym, last_col;
  logic          wb, rb;
  logic          m, have_last, ack_gap;
  logic          wr_en, wr_last, rd_ok, ack_ok, nrs_col, m_eff;
  logic [2:0]    vs_m, off;
  logic [3:0]    off_sum, row;
  logic [AW-1:0] wr_addr, rd_addr;

`ifndef NRS_DEMAP_PINGPONG_EN
  assign wb = 1'b0;
  assign rb = 1'b0;
`endif

  assign fft_ready   = (state[wb] != FULL);
  // ack_gap forces a one-cycle low when reading hops straight onto an already full bank
  assign demap_ready = (state[rb] == FULL) && !ack_gap;
  assign wr_en       = fft_valid && fft_ready;
  assign wr_last     = (sym == 4'(N_SYM - 1)) && (sc == 4'(N_SC - 1));
  assign rd_ok       = demap_read && demap_ready;
  assign ack_ok      = est_ack_demap && demap_ready;
  assign nrs_col     = col_demap inside {4'd5, 4'd6, 4'd12, 4'd13};

  assign vs_m    = (vs_bank[rb] >= 3'd6) ? vs_bank[rb] - 3'd6 : vs_bank[rb];
  assign off_sum = {1'b0, vs_m} + ((col_demap == 4'd6 || col_demap == 4'd13) ? 4'd3 : 4'd0);
  assign off     = (off_sum >= 4'd6) ? 3'(off_sum - 4'd6) : off_sum[2:0];
  assign m_eff   = have_last && (col_demap == last_col) && m;
  assign row     = {1'b0, off} + (m_eff ? 4'd6 : 4'd0);

  assign wr_addr = AW'(wb) * AW'(DEPTH) + AW'(sym) * AW'(N_SC) + AW'(sc);
  assign rd_addr = AW'(rb) * AW'(DEPTH) + AW'(col_demap) * AW'(N_SC) + AW'(row);

  always_ff @(posedge clk) begin
    if (rst && wr_en)
      mem[wr_addr] <= {fft_r, fft_i};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sc         <= '0;
      sym        <= '0;
      state[0]   <= EMPTY;
      state[1]   <= EMPTY;
      vs_bank[0] <= '0;
      vs_bank[1] <= '0;
      m          <= 1'b0;
      have_last  <= 1'b0;
      last_col   <= '0;
      ack_gap    <= 1'b0;
      rx_r       <= '0;
      rx_i       <= '0;
      col_err    <= 1'b0;
`ifdef NRS_DEMAP_PINGPONG_EN
      wb         <= 1'b0;
      rb         <= 1'b0;
`endif
    end else begin
      col_err <= 1'b0;
      ack_gap <= ack_ok;

      if (wr_en) begin
        if (wr_last) begin
          sc          <= '0;
          sym         <= '0;
          state[wb]   <= FULL;
          vs_bank[wb] <= v_shift;
`ifdef NRS_DEMAP_PINGPONG_EN
          wb          <= ~wb;
`endif
        end else begin
          state[wb] <= FILL;
          if (sc == 4'(N_SC - 1)) begin
            sc  <= '0;
            sym <= sym + 4'd1;
          end else begin
            sc <= sc + 4'd1;
          end
        end
      end

      if (rd_ok) begin
        if (nrs_col) begin
          {rx_r, rx_i} <= mem[rd_addr];
          m            <= ~m_eff;
          have_last    <= 1'b1;
          last_col     <= col_demap;
        end else begin
          rx_r    <= '0;
          rx_i    <= '0;
          col_err <= 1'b1;
        end
      end

      // The same-cycle read above has already sampled this bank before it is released
      if (ack_ok) begin
        state[rb] <= EMPTY;
        m         <= 1'b0;
`ifdef NRS_DEMAP_PINGPONG_EN
        rb        <= ~rb;
`endif
      end
    end
  end

endmodule

// File: tb/tb_nrs_re_demapper.sv
// tb/tb_nrs_re_demapper.sv - directed self-checking bench for nrs_re_demapper
module tb_nrs_re_demapper;

  logic               clk;
  logic               rst;
  logic               fft_valid;
  logic signed [15:0] fft_r, fft_i;
  logic               fft_ready;
  logic [2:0]         v_shift;
  logic [3:0]         col_demap;
  logic               demap_read;
  logic               est_ack_demap;
  logic               demap_ready;
  logic signed [15:0] rx_r, rx_i;
  logic               col_err;

  int checks = 0;
  int errors = 0;

  nrs_re_demapper #(.WIDTH_RX(16), .N_SC(12), .N_SYM(14)) dut (
    .clk          (clk),
    .rst          (rst),
    .fft_valid    (fft_valid),
    .fft_r        (fft_r),
    .fft_i        (fft_i),
    .fft_ready    (fft_ready),
    .v_shift      (v_shift),
    .col_demap    (col_demap),
    .demap_read   (demap_read),
    .est_ack_demap(est_ack_demap),
    .demap_ready  (demap_ready),
    .rx_r         (rx_r),
    .rx_i         (rx_i),
    .col_err      (col_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Streams n samples valued first..first+n-1 (imag negated); inputs change on negedge.
  task automatic send(input int first, input int n, input logic [2:0] vs);
    for (int i = 0; i < n; i++) begin
      int waited = 0;
      while (!fft_ready && waited < 400) begin
        @(negedge clk);
        waited++;
      end
      if (!fft_ready) begin
        check("fft_ready_wait", fft_ready, 1'b1);
        fft_valid = 1'b0;
        return;
      end
      fft_valid = 1'b1;
      fft_r     = 16'(first + i);
      fft_i     = 16'(-(first + i));
      v_shift   = vs;
      @(negedge clk);
    end
    fft_valid = 1'b0;
  endtask

  task automatic rd(input logic [3:0] col, input logic ack);
    demap_read    = 1'b1;
    col_demap     = col;
    est_ack_demap = ack;
    @(negedge clk);
    demap_read    = 1'b0;
    est_ack_demap = 1'b0;
  endtask

  task automatic ack_only();
    est_ack_demap = 1'b1;
    @(negedge clk);
    est_ack_demap = 1'b0;
  endtask

  initial begin
    rst = 1'b0; fft_valid = 1'b0; fft_r = '0; fft_i = '0; v_shift = '0;
    col_demap = '0; demap_read = 1'b0; est_ack_demap = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_fft_ready", fft_ready, 1'b1);
    check("rst_demap_ready", demap_ready, 1'b0);
    check("rst_rx_r", rx_r, 0);
    check("rst_rx_i", rx_i, 0);
    check("rst_col_err", col_err, 1'b0);
    rst = 1'b1;
    @(negedge clk);

    rd(4'd5, 1'b0);
    check("early_read_rx_r", rx_r, 0);
    check("early_read_col_err", col_err, 1'b0);

    send(0, 167, 3'd2);
    check("fill167_demap_ready", demap_ready, 1'b0);
    send(167, 1, 3'd2);
    check("fill_demap_ready", demap_ready, 1'b1);

`ifndef NRS_DEMAP_PINGPONG_EN
    check("full_fft_ready", fft_ready, 1'b0);
    fft_valid = 1'b1; fft_r = 16'sd999; fft_i = -16'sd999;
    repeat (3) @(negedge clk);
    fft_valid = 1'b0;
    check("stall_fft_ready", fft_ready, 1'b0);
`endif

    demap_read = 1'b1; col_demap = 4'd5;
    @(negedge clk);
    check("c5_a_rx_r", rx_r, 62);
    check("c5_a_rx_i", rx_i, -62);
    @(negedge clk);
    demap_read = 1'b0;
    check("c5_b_rx_r", rx_r, 68);
    check("c5_b_rx_i", rx_i, -68);
    @(negedge clk);
    check("c5_hold_rx_r", rx_r, 68);

    rd(4'd6, 1'b0);
    check("c6_a_rx_r", rx_r, 77);
    rd(4'd6, 1'b0);
    check("c6_b_rx_r", rx_r, 83);

    rd(4'd3, 1'b0);
    check("c3_rx_r", rx_r, 0);
    check("c3_rx_i", rx_i, 0);
    check("c3_col_err", col_err, 1'b1);
    @(negedge clk);
    check("c3_col_err_pulse", col_err, 1'b0);
    rd(4'd12, 1'b0);
    check("c12_a_rx_r", rx_r, 146);
    check("c12_a_col_err", col_err, 1'b0);
    rd(4'd3, 1'b0);
    check("c3_again_col_err", col_err, 1'b1);
    rd(4'd12, 1'b0);
    check("c12_b_rx_r", rx_r, 152);

`ifdef NRS_DEMAP_PINGPONG_EN
    send(1000, 168, 3'd4);
    check("pp_both_full_fft_ready", fft_ready, 1'b0);
    check("pp_both_full_demap_ready", demap_ready, 1'b1);
    ack_only();
    check("pp_ack_gap_demap_ready", demap_ready, 1'b0);
    check("pp_ack_fft_ready", fft_ready, 1'b1);
    @(negedge clk);
    check("pp_ack_reassert", demap_ready, 1'b1);
`else
    ack_only();
    check("ack_demap_ready", demap_ready, 1'b0);
    check("ack_fft_ready", fft_ready, 1'b1);
    rd(4'd5, 1'b0);
    check("ignored_read_rx_r", rx_r, 152);
    check("ignored_read_col_err", col_err, 1'b0);
    send(1000, 168, 3'd4);
    check("refill_demap_ready", demap_ready, 1'b1);
`endif
    rd(4'd13, 1'b0);
    check("c13_a_rx_r", rx_r, 1157);
    rd(4'd13, 1'b0);
    check("c13_b_rx_r", rx_r, 1163);
    check("c13_b_rx_i", rx_i, -1163);
    ack_only();
    check("second_ack_demap_ready", demap_ready, 1'b0);

    send(5000, 50, 3'd2);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("midrst_fft_ready", fft_ready, 1'b1);
    check("midrst_demap_ready", demap_ready, 1'b0);
    send(2000, 167, 3'd2);
    check("new167_demap_ready", demap_ready, 1'b0);
    send(2167, 1, 3'd2);
    check("new168_demap_ready", demap_ready, 1'b1);
    rd(4'd5, 1'b0);
    check("new_c5_a_rx_r", rx_r, 2062);
    rd(4'd5, 1'b0);
    check("new_c5_b_rx_r", rx_r, 2068);
    check("new_c5_b_rx_i", rx_i, -2068);

    rd(4'd5, 1'b1);
    check("rdack_rx_r", rx_r, 2062);
    check("rdack_demap_ready", demap_ready, 1'b0);
    rd(4'd5, 1'b0);
    check("post_ack_read_rx_r", rx_r, 2062);
    check("post_ack_read_col_err", col_err, 1'b0);
    check("post_ack_fft_ready", fft_ready, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nrs_re_demapper.md
# nrs_re_demapper

Resource-element buffer and NRS demapper serving the channel estimator in the NB-IoT receive chain. It collects one subframe of frequency-domain samples from the FFT stage (12 subcarriers × 14 symbols) and raises `demap_ready` when the subframe is complete. It then answers the estimator's column/read requests with the narrowband reference signal (NRS) resource elements located by `v_shift`, and releases the buffer on `est_ack_demap`.

## Interface
- `WIDTH_RX`, 16, sample width per real/imag component (signed)
- `N_SC`, 12, subcarriers per symbol
- `N_SYM`, 14, symbols per subframe
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  synchronous, active-low reset
- `fft_valid`  in  1  FFT sample valid
- `fft_r`, `fft_i`  in  WIDTH_RX each  FFT sample, subcarrier-major order within each symbol
- `fft_ready`  out  1  block can accept a sample
- `v_shift`  in  3  cell-specific NRS shift, 0..5
- `col_demap`  in  4  requested OFDM symbol index
- `demap_read`  in  1  request one NRS element of `col_demap`
- `est_ack_demap`  in  1  estimator finished with the current subframe
- `demap_ready`  out  1  a full subframe is available for reading
- `rx_r`, `rx_i`  out  WIDTH_RX each  returned NRS element
- `col_err`  out  1  one-cycle pulse when a read targets a non-NRS column

## Operation
- Write side:
  - Counters `sc` (0..11) and `sym` (0..13); a sample is written when `fft_valid && fft_ready`.
  - Write address = `sym*12 + sc` (168 entries per bank).
  - The write with `sym=13, sc=11` marks the bank full, latches `v_shift` as `vs`, and wraps both counters to 0.
- State machine per bank: EMPTY → FILL on the first write → FULL on the last write → EMPTY on `est_ack_demap` while that bank is the read bank.
- NRS columns are 5, 6, 12 and 13.
  - Offset `off = (vs + (col==6 || col==13 ? 3 : 0)) mod 6`.
  - `vs` values 6 and 7 are reduced mod 6.
- Read side:
  - Each accepted `demap_read` returns row `off + 6*m`.
  - `m` is a 1-bit pointer. It toggles after each valid read and resets to 0 when `col_demap` differs from the previous valid read's column, and on ack.
- A read to a column outside {5, 6, 12, 13}:
  - drives `rx_r`/`rx_i` = 0 and pulses `col_err`;
  - leaves `m` unchanged.
- `demap_read` while `demap_ready=0` is ignored: outputs hold and `col_err` stays 0.
- `est_ack_demap` while `demap_ready=0` is ignored.
- Read and ack in the same cycle: the read is serviced from the current bank, then the bank is released.
- Reset:
  - clears counters, bank states, `m` and `vs`;
  - discards any partially filled subframe;
  - does not require clearing buffer contents.
- Reset values: `fft_ready=1`, `demap_ready=0`, `rx_r=0`, `rx_i=0`, `col_err=0`.

## Timing
- `demap_ready` rises on the cycle after the last sample is written.
- `demap_ready` falls on the cycle after an accepted `est_ack_demap`.
- Read latency is 1 cycle: `rx_r`/`rx_i` are registered and valid on the cycle after `demap_read`, then hold until the next accepted read.
- `col_err` is asserted on the same cycle as the returned data and lasts exactly 1 cycle.
- Back-to-back `demap_read` every cycle is supported.
- `fft_ready` is combinational from the bank state only, not from `fft_valid`.

## Configuration
- `NRS_DEMAP_PINGPONG_EN` defined:
  - Two banks; the FFT fills one while the estimator reads the other.
  - `fft_ready=0` only when both banks are FULL.
  - On ack, reading moves to the other bank. If that bank is already FULL, `demap_ready` drops for exactly 1 cycle, then reasserts.
- Not defined:
  - Single bank.
  - `fft_ready=0` from the cycle after the last write until the cycle after `est_ack_demap`.
  - Samples presented while `fft_ready=0` are not consumed.

## Test plan
- Fill ramp (`fft_r = addr`, `fft_i = -addr`) with `v_shift=2`; read col 5 twice → `rx_r` = 62 then 68, `rx_i` = -62 then -68, each 1 cycle after its read.
- Same subframe, read col 6 twice → `rx_r` = 77 then 83. Refill with `v_shift=4`, read col 13 twice → `rx_r` = 157 then 163.
- Read col 3 → `rx_r=0`, `rx_i=0`, `col_err` high for 1 cycle. A following read of col 12 (`v_shift=2`) → `rx_r` = 146 (`m` unaffected by the bad read).
- Backpressure without the macro: after 168 samples `fft_ready=0` and `demap_ready=1`; assert ack → `demap_ready=0` and `fft_ready=1` next cycle. With the macro: a second subframe is accepted, the 337th sample stalls, ack → `demap_ready` low 1 cycle then high.
- Assert `rst=0` after 50 samples, release, stream 168 new samples → `demap_ready=1` only after the 168th new sample, and reads return the new data.
- Assert `demap_read` (col 5) and `est_ack_demap` in the same cycle → data returned from the released bank, then `demap_ready=0`; the next read is ignored.
